// File: rtl/shift_deser_rx.sv
// Framed serial receiver (start, WIDTH data bits, optional parity, stop) with valid/ack handshake.
// Define SHIFTRX_PARITY_EN to insert one parity bit after the data; its sense is set by PARITY_ODD.
module shift_deser_rx #(
    parameter int WIDTH      = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             InS,
    input  logic             InEn,
    input  logic             RL,
    input  logic             Ack,
    output logic [WIDTH-1:0] D,
    output logic             Valid,
    output logic             FrameErr,
    output logic             Overrun
);

`ifdef SHIFTRX_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             rl_q;
    logic             perr;
    logic             fin_good;
    logic             fin_bad;

    logic             start_bit;
    logic             data_bit;
    logic             par_bit;
    logic             stop_bit;
    logic             good;
    logic             bad;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge CLK) begin
        if (Clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        if (InEn) begin
            case (state)
                IDLE: if (!InS) state_nxt = DATA;
`ifdef SHIFTRX_PARITY_EN
                DATA: if (cnt == LAST) state_nxt = PAR;
                PAR:  state_nxt = STOP;
`else
                DATA: if (cnt == LAST) state_nxt = STOP;
`endif
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        start_bit = 1'b0;
        data_bit  = 1'b0;
        par_bit   = 1'b0;
        stop_bit  = 1'b0;
        if (InEn) begin
            case (state)
                IDLE: start_bit = !InS;
                DATA: data_bit  = 1'b1;
`ifdef SHIFTRX_PARITY_EN
                PAR:  par_bit   = 1'b1;
`endif
                STOP:    stop_bit = 1'b1;
                default: ;
            endcase
        end
    end

    assign good = stop_bit && InS && !perr;
    assign bad  = stop_bit && !good;

    // Receive datapath; fin_* carry the frame verdict to the handshake one edge later.
    always_ff @(negedge CLK) begin
        if (Clear) begin
            sh       <= '0;
            cnt      <= '0;
            rl_q     <= 1'b0;
            perr     <= 1'b0;
            fin_good <= 1'b0;
            fin_bad  <= 1'b0;
        end else begin
            fin_good <= good;
            fin_bad  <= bad;
            if (start_bit) begin
                rl_q <= RL;
                sh   <= '0;
                cnt  <= '0;
                perr <= 1'b0;
            end
            if (data_bit) begin
                if (rl_q) begin
                    sh <= {sh[WIDTH-2:0], InS};
                end else begin
                    sh <= {InS, sh[WIDTH-1:1]};
                end
                cnt <= cnt + CW'(1);
            end
            if (par_bit) begin
                perr <= InS ^ (^sh) ^ PARITY_ODD;
            end
        end
    end

    // Handshake runs on every edge; sh is still intact on the edge after the stop bit.
    always_ff @(negedge CLK) begin
        if (Clear) begin
            D        <= '0;
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            FrameErr <= fin_bad;
            if (fin_good) begin
                if (!Valid || Ack) begin
                    D     <= sh;
                    Valid <= 1'b1;
                end
            end else if (Ack) begin
                Valid <= 1'b0;
            end
            if (fin_good && Valid && !Ack) begin
                Overrun <= 1'b1;
            end else if (Ack) begin
                Overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_deser_rx.sv
// Self-checking bench for shift_deser_rx: frame-level reference model compared every cycle,
// directed literal checks, then randomized frames with gaps, errors, RL flips, Ack and Clear.
module tb_shift_deser_rx;

    localparam int W   = 4;
    localparam bit ODD = 1'b0;
`ifdef SHIFTRX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         CLK = 1'b0;
    logic         Clear;
    logic         InS;
    logic         InEn;
    logic         RL;
    logic         Ack;
    logic [W-1:0] D;
    logic         Valid;
    logic         FrameErr;
    logic         Overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    shift_deser_rx #(.WIDTH(W), .PARITY_ODD(ODD)) dut (
        .CLK(CLK), .Clear(Clear), .InS(InS), .InEn(InEn), .RL(RL), .Ack(Ack),
        .D(D), .Valid(Valid), .FrameErr(FrameErr), .Overrun(Overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects strobed line bits per frame and decodes the whole frame at once.
    logic [W-1:0] m_d;
    bit           m_valid, m_ferr, m_ovr, model_ok;
    bit           pend_good, pend_bad, set_ovr, m_perr;
    logic [W-1:0] pend_word, m_w;
    bit           in_frame, frame_rl;
    bit           bits[$];

    always @(negedge CLK) begin
        if (Clear) begin
            m_d = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
            pend_good = 0; pend_bad = 0; in_frame = 0;
            bits.delete();
            model_ok = 1;
        end else begin
            m_ferr  = pend_bad;
            set_ovr = pend_good && m_valid && !Ack;
            if (pend_good && (!m_valid || Ack)) begin
                m_d     = pend_word;
                m_valid = 1;
            end else if (!pend_good && Ack) begin
                m_valid = 0;
            end
            if (set_ovr) m_ovr = 1;
            else if (Ack) m_ovr = 0;
            pend_good = 0;
            pend_bad  = 0;
            if (InEn) begin
                if (!in_frame) begin
                    if (InS == 1'b0) begin
                        in_frame = 1;
                        frame_rl = RL;
                        bits.delete();
                    end
                end else begin
                    bits.push_back(InS);
                    if (bits.size() == W + P + 1) begin
                        m_w = '0;
                        for (int i = 0; i < W; i++) begin
                            if (frame_rl) m_w[W-1-i] = bits[i];
                            else          m_w[i]     = bits[i];
                        end
                        m_perr    = (P == 1) && (bits[W] != ((($countones(m_w) % 2) == 1) ^ ODD));
                        pend_good = bits[W+P] && !m_perr;
                        pend_bad  = !pend_good;
                        pend_word = m_w;
                        in_frame  = 0;
                    end
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (model_ok) begin
            check("cyc_D", 32'(D), 32'(m_d));
            check("cyc_Valid", 32'(Valid), 32'(m_valid));
            check("cyc_FrameErr", 32'(FrameErr), 32'(m_ferr));
            check("cyc_Overrun", 32'(Overrun), 32'(m_ovr));
        end
    end

    task automatic drive(input bit b, input bit en, input bit a, input bit rl, input bit clr);
        @(posedge CLK);
        InS = b; InEn = en; Ack = a; RL = rl; Clear = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends v[n-1] first; start is v[n-1], stop is v[0]; a correct parity bit is inserted when compiled in.
    task automatic line(input logic [15:0] v, input int n, input bit rl);
        bit par;
        par = ODD;
        for (int i = n - 1; i >= 1; i--) begin
            drive(v[i], 1'b1, 1'b0, rl, 1'b0);
            if (i < n - 1) par ^= v[i];
        end
        if (P == 1) drive(par, 1'b1, 1'b0, rl, 1'b0);
        drive(v[0], 1'b1, 1'b0, rl, 1'b0);
    endtask

    task automatic ack_once();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
    endtask

    logic [W-1:0] r_w;
    bit           r_rl, r_bad_stop, r_bad_par, r_clr, r_par;
    bit           r_lb[$];

    initial begin
        Clear = 1'b1; InS = 1'b1; InEn = 1'b0; RL = 1'b0; Ack = 1'b0;

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("rst_D", 32'(D), 32'h0);
        check("rst_Valid", 32'(Valid), 32'h0);
        check("rst_FrameErr", 32'(FrameErr), 32'h0);
        check("rst_Overrun", 32'(Overrun), 32'h0);

        line(16'b010111, 6, 1'b0);
        idle(2);
        check("lsb_D", 32'(D), 32'hD);
        check("lsb_Valid", 32'(Valid), 32'h1);
        idle(3);
        check("lsb_Valid_hold", 32'(Valid), 32'h1);
        ack_once();
        check("lsb_Valid_ack", 32'(Valid), 32'h0);

        line(16'b010111, 6, 1'b1);
        idle(2);
        check("msb_D", 32'(D), 32'hB);
        ack_once();

        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        if (P == 1) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("rlflip_D", 32'(D), 32'hB);
        check("rlflip_Valid", 32'(Valid), 32'h1);
        ack_once();

        line(16'b010110, 6, 1'b0);
        idle(2);
        check("stop_FrameErr", 32'(FrameErr), 32'h1);
        check("stop_Valid", 32'(Valid), 32'h0);
        check("stop_D", 32'(D), 32'hB);
        idle(1);
        check("stop_FrameErr_gone", 32'(FrameErr), 32'h0);

        line(16'b011001, 6, 1'b0);
        line(16'b000111, 6, 1'b0);
        idle(2);
        check("ovr_D", 32'(D), 32'h3);
        check("ovr_Overrun", 32'(Overrun), 32'h1);
        ack_once();
        check("ovr_Valid_ack", 32'(Valid), 32'h0);
        check("ovr_Overrun_ack", 32'(Overrun), 32'h0);

        line(16'b011001, 6, 1'b0);
        line(16'b000111, 6, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("ackc_D", 32'(D), 32'hC);
        check("ackc_Valid", 32'(Valid), 32'h1);
        check("ackc_Overrun", 32'(Overrun), 32'h0);
        ack_once();

`ifdef SHIFTRX_PARITY_EN
        for (int i = 6; i >= 0; i--) drive(7'b0111001 >> i, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("par_bad_FrameErr", 32'(FrameErr), 32'h1);
        check("par_bad_Valid", 32'(Valid), 32'h0);
        for (int i = 6; i >= 0; i--) drive(7'b0111011 >> i, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("par_ok_D", 32'(D), 32'h7);
        check("par_ok_FrameErr", 32'(FrameErr), 32'h0);
        ack_once();
`endif

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("clr_FrameErr", 32'(FrameErr), 32'h0);
        check("clr_Valid", 32'(Valid), 32'h0);
        check("clr_Overrun", 32'(Overrun), 32'h0);
        line(16'b010101, 6, 1'b0);
        idle(2);
        check("clr_next_D", 32'(D), 32'h5);
        ack_once();

        for (int f = 0; f < 300; f++) begin
            r_w        = W'($urandom);
            r_rl       = 1'($urandom);
            r_bad_stop = ($urandom % 8) == 0;
            r_bad_par  = ($urandom % 8) == 0;
            r_clr      = ($urandom % 16) == 0;
            r_lb.delete();
            r_lb.push_back(1'b0);
            for (int i = 0; i < W; i++) r_lb.push_back(r_rl ? r_w[W-1-i] : r_w[i]);
            r_par = (^r_w) ^ ODD ^ r_bad_par;
            if (P == 1) r_lb.push_back(r_par);
            r_lb.push_back(!r_bad_stop);
            for (int k = 0; k < r_lb.size(); k++) begin
                repeat ($urandom % 3) drive(1'($urandom), 1'b0, ($urandom % 4) == 0, 1'($urandom), 1'b0);
                drive(r_lb[k], 1'b1, ($urandom % 4) == 0, (k == 0) ? r_rl : 1'($urandom),
                      r_clr && (k == r_lb.size() / 2));
            end
            if (r_clr) repeat (W + P + 2) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            repeat ($urandom % 3) drive(1'b1, 1'b1, ($urandom % 4) == 0, 1'($urandom), 1'b0);
        end

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
